// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback buffer and its forwarding search.
package wb_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match forwarding search for one read port over the queued entries
// (index 0 = newest) and the registered output stage.
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [REG_IDX_W-1:0]  rd_reg,
    input  wb_entry_t [DEPTH-1:0] entries,
    input  logic [DEPTH-1:0]      entry_valid,
    input  logic                  stage_valid,
    input  wb_entry_t             stage,
    output logic                  hit,
    output logic [XLEN-1:0]       data
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        hit  = 1'b0;
        data = '0;
        if (rd_reg != '0) begin
            if (stage_valid && stage.rd == rd_reg) begin
                hit  = 1'b1;
                data = stage.data;
            end
            // Oldest to newest, so the newest match is the last assignment and wins.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (entry_valid[k] && entries[k].rd == rd_reg) begin
                    hit  = 1'b1;
                    data = entries[k].data;
                end
            end
        end
    end

endmodule

// File: rtl/writeback_buffer.sv
// Pending-write FIFO in front of the 32x32 register file with youngest-match forwarding.
// Optional WB_PERF_CNT_EN adds saturating performance counters. XLEN must equal wb_pkg::XLEN.
module writeback_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = wb_pkg::XLEN
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [wb_pkg::REG_IDX_W-1:0]  in_rd,
    input  logic [XLEN-1:0]               in_data,
    input  logic                          hold,
    output logic                          wr_en,
    output logic [wb_pkg::REG_IDX_W-1:0]  wr_reg,
    output logic [XLEN-1:0]               wr_data,
    input  logic [wb_pkg::REG_IDX_W-1:0]  rd_reg_1,
    input  logic [wb_pkg::REG_IDX_W-1:0]  rd_reg_2,
    output logic                          fwd_hit_1,
    output logic [XLEN-1:0]               fwd_data_1,
    output logic                          fwd_hit_2,
    output logic [XLEN-1:0]               fwd_data_2,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          empty
`ifdef WB_PERF_CNT_EN
   ,output logic [31:0]                   perf_retired,
    output logic [31:0]                   perf_dropped,
    output logic [31:0]                   perf_stall_cycles
`endif
);

    import wb_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    wb_entry_t             mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [IDX_W-1:0]      wr_idx, rd_idx;
    logic                  full, drain, accept, push;
    wb_entry_t [DEPTH-1:0] ordered;
    logic [DEPTH-1:0]      ordered_valid;

    assign wr_idx   = wr_ptr[IDX_W-1:0];
    assign rd_idx   = rd_ptr[IDX_W-1:0];
    assign full     = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_idx == rd_idx);
    assign empty    = (wr_ptr == rd_ptr);
    assign count    = wr_ptr - rd_ptr;
    assign drain    = !hold && !empty;
    assign in_ready = !full || drain;
    assign accept   = in_valid && in_ready;
    assign push     = accept && (in_rd != '0);   // x0 writes complete the handshake but are dropped

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (drain) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; validity comes entirely from the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= '{rd: in_rd, data: in_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_reg  <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= drain;
            if (drain) begin
                wr_reg  <= mem[rd_idx].rd;
                wr_data <= mem[rd_idx].data;
            end
        end
    end

    // Present the queue newest-first to the forwarding search.
    for (genvar k = 0; k < DEPTH; k++) begin : g_order
        logic [IDX_W-1:0] idx;
        assign idx              = wr_idx - IDX_W'(k + 1);
        assign ordered[k]       = mem[idx];
        assign ordered_valid[k] = (PTR_W'(k) < count);
    end

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_1 (
        .rd_reg      (rd_reg_1),
        .entries     (ordered),
        .entry_valid (ordered_valid),
        .stage_valid (wr_en),
        .stage       ('{rd: wr_reg, data: wr_data}),
        .hit         (fwd_hit_1),
        .data        (fwd_data_1)
    );

    wb_fwd_match #(.DEPTH(DEPTH)) u_fwd_2 (
        .rd_reg      (rd_reg_2),
        .entries     (ordered),
        .entry_valid (ordered_valid),
        .stage_valid (wr_en),
        .stage       ('{rd: wr_reg, data: wr_data}),
        .hit         (fwd_hit_2),
        .data        (fwd_data_2)
    );

`ifdef WB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_retired      <= '0;
            perf_dropped      <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (wr_en && perf_retired != '1)
                perf_retired <= perf_retired + 1'b1;
            if (accept && in_rd == '0 && perf_dropped != '1)
                perf_dropped <= perf_dropped + 1'b1;
            if (in_valid && !in_ready && perf_stall_cycles != '1)
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
        end
    end
`endif

    // A producer refused this cycle must keep offering the same result.
    property p_hold_offer;
        @(posedge clk) disable iff (rst)
        (in_valid && !in_ready) |=> (in_valid && $stable(in_rd) && $stable(in_data));
    endproperty
    a_hold_offer: assert property (p_hold_offer);

endmodule

// File: tb/tb_writeback_buffer.sv
// Self-checking bench for writeback_buffer: vector table plus directed multi-cycle sequences.
module tb_writeback_buffer;

    logic        clk, rst;
    logic        in_valid, in_ready, hold;
    logic [4:0]  in_rd;
    logic [31:0] in_data;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [31:0] wr_data;
    logic [4:0]  rd_reg_1, rd_reg_2;
    logic        fwd_hit_1, fwd_hit_2;
    logic [31:0] fwd_data_1, fwd_data_2;
    logic [2:0]  count;
    logic        empty;

    writeback_buffer #(.DEPTH(4), .XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rd      (in_rd),
        .in_data    (in_data),
        .hold       (hold),
        .wr_en      (wr_en),
        .wr_reg     (wr_reg),
        .wr_data    (wr_data),
        .rd_reg_1   (rd_reg_1),
        .rd_reg_2   (rd_reg_2),
        .fwd_hit_1  (fwd_hit_1),
        .fwd_data_1 (fwd_data_1),
        .fwd_hit_2  (fwd_hit_2),
        .fwd_data_2 (fwd_data_2),
        .count      (count),
        .empty      (empty)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        hold, valid;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  r1, r2;
        logic [2:0]  cnt;
        logic        emp, rdy, wen, h1;
        logic [31:0] d1;
        logic        h2;
        logic [31:0] d2;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t tbl [15];
    int   checks = 0;
    int   errors = 0;
    int   wr_pulses = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write pulse must match the oldest expected result.
    always @(posedge clk) begin
        #2;
        if (wr_en === 1'b1) begin
            wr_pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got reg %0d data 0x%0h, expected no write", wr_reg, wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_wr_reg", 32'(wr_reg), 32'(mon_e.rd));
                check("sb_wr_data", wr_data, mon_e.data);
            end
        end
    end

    // Offer one result at the current negedge, wait (bounded) for acceptance.
    task automatic push(input logic [4:0] rd, input logic [31:0] d);
        int w = 0;
        in_valid = 1'b1;
        in_rd    = rd;
        in_data  = d;
        #1;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            #1;
            w++;
        end
        check("push_ready", 32'(in_ready), 32'd1);
        if (rd != 5'd0) exp_q.push_back('{rd: rd, data: d});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0; hold = 1'b0;
        rd_reg_1 = 5'd5; rd_reg_2 = 5'd5;

        //              hold  valid rd     data           r1     r2     cnt   emp   rdy   wen   h1    d1             h2    d2
        tbl[0]  = '{1'b1, 1'b1, 5'd7, 32'hA,        5'd7, 5'd3, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b1, 5'd7, 32'hB,        5'd7, 5'd3, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA,  1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd7, 5'd0, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 32'hB,  1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b1, 5'd3, 32'h33,       5'd0, 5'd7, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'hB};
        tbl[4]  = '{1'b1, 1'b1, 5'd9, 32'h99,       5'd3, 5'd7, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 32'h33, 1'b1, 32'hB};
        tbl[5]  = '{1'b1, 1'b0, 5'd0, 32'h0,        5'd9, 5'd3, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 32'h99, 1'b1, 32'h33};
        tbl[6]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd9, 3'd4, 1'b0, 1'b1, 1'b0, 1'b1, 32'hB,  1'b1, 32'h99};
        tbl[7]  = '{1'b1, 1'b0, 5'd0, 32'h0,        5'd7, 5'd5, 3'd3, 1'b0, 1'b1, 1'b1, 1'b1, 32'hB,  1'b0, 32'h0};
        tbl[8]  = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd3, 3'd3, 1'b0, 1'b1, 1'b0, 1'b1, 32'hB,  1'b1, 32'h33};
        tbl[9]  = '{1'b1, 1'b0, 5'd0, 32'h0,        5'd7, 5'd3, 3'd2, 1'b0, 1'b1, 1'b1, 1'b1, 32'hB,  1'b1, 32'h33};
        tbl[10] = '{1'b1, 1'b0, 5'd0, 32'h0,        5'd7, 5'd9, 3'd2, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b1, 32'h99};
        tbl[11] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd3, 5'd9, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 32'h33, 1'b1, 32'h99};
        tbl[12] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd3, 5'd9, 3'd1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h33, 1'b1, 32'h99};
        tbl[13] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd3, 5'd9, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0,  1'b1, 32'h99};
        tbl[14] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd9, 5'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_reg", 32'(wr_reg), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_hit_1", 32'(fwd_hit_1), 32'd0);
        check("rst_data_1", fwd_data_1, 32'd0);
        check("rst_hit_2", 32'(fwd_hit_2), 32'd0);
        check("rst_data_2", fwd_data_2, 32'd0);

        // Single enqueue: write pulse the clock after the handshake edge
        push(5'd5, 32'hDEADBEEF);
        #1;
        check("lat_wr_en_early", 32'(wr_en), 32'd0);
        check("lat_count_1", 32'(count), 32'd1);
        check("lat_fwd_queue", fwd_data_1, 32'hDEADBEEF);
        @(negedge clk); #1;
        check("lat_wr_en", 32'(wr_en), 32'd1);
        check("lat_wr_reg", 32'(wr_reg), 32'd5);
        check("lat_wr_data", wr_data, 32'hDEADBEEF);
        check("lat_count_0", 32'(count), 32'd0);
        check("lat_fwd_stage", 32'(fwd_hit_1), 32'd1);
        @(negedge clk); #1;
        check("lat_wr_en_done", 32'(wr_en), 32'd0);
        check("lat_fwd_gone", 32'(fwd_hit_1), 32'd0);
        @(negedge clk);

        // Table-driven vectors: forwarding priority, x0 drop, full/hold, drain
        for (int i = 0; i < 15; i++) begin
            hold     = tbl[i].hold;
            in_valid = tbl[i].valid;
            in_rd    = tbl[i].rd;
            in_data  = tbl[i].data;
            rd_reg_1 = tbl[i].r1;
            rd_reg_2 = tbl[i].r2;
            #1;
            check($sformatf("row%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            check($sformatf("row%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
            check($sformatf("row%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            check($sformatf("row%0d_wr_en", i), 32'(wr_en), 32'(tbl[i].wen));
            check($sformatf("row%0d_hit_1", i), 32'(fwd_hit_1), 32'(tbl[i].h1));
            check($sformatf("row%0d_data_1", i), fwd_data_1, tbl[i].d1);
            check($sformatf("row%0d_hit_2", i), 32'(fwd_hit_2), 32'(tbl[i].h2));
            check($sformatf("row%0d_data_2", i), fwd_data_2, tbl[i].d2);
            if (tbl[i].valid && tbl[i].rdy && tbl[i].rd != 5'd0)
                exp_q.push_back('{rd: tbl[i].rd, data: tbl[i].data});
            @(negedge clk);
        end
        in_valid = 1'b0;
        hold     = 1'b0;

        // Fill under hold, then release: four back-to-back writes in order
        hold = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'(i * 32'h11));
        #1;
        check("fill_count", 32'(count), 32'd4);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        hold = 1'b0;
        p0 = wr_pulses;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check($sformatf("burst_wr_en_%0d", i), 32'(wr_en), 32'd1);
        end
        @(negedge clk); #1;
        check("burst_idle", 32'(wr_en), 32'd0);
        check("burst_count", 32'(count), 32'd0);
        check("burst_pulses", 32'(wr_pulses - p0), 32'd4);

        // x0 write: accepted, never stored, never written, never forwarded
        p0 = wr_pulses;
        rd_reg_1 = 5'd0;
        rd_reg_2 = 5'd0;
        push(5'd0, 32'hFFFFFFFF);
        #1;
        check("x0_count", 32'(count), 32'd0);
        check("x0_empty", 32'(empty), 32'd1);
        check("x0_hit_1", 32'(fwd_hit_1), 32'd0);
        check("x0_data_1", fwd_data_1, 32'd0);
        repeat (3) @(negedge clk);
        check("x0_no_write", 32'(wr_pulses - p0), 32'd0);

        // Full buffer streaming through pointer wrap
        hold = 1'b1;
        for (int i = 0; i < 4; i++) push(5'(20 + i), $urandom);
        hold = 1'b0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_rd    = 5'(8 + i);
            in_data  = $urandom;
            #1;
            check($sformatf("stream_ready_%0d", i), 32'(in_ready), 32'd1);
            check($sformatf("stream_count_%0d", i), 32'(count), 32'd4);
            exp_q.push_back('{rd: in_rd, data: in_data});
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        check("stream_drained", 32'(count), 32'd0);

        // Reset with entries pending while a write pulse is in flight
        @(negedge clk);
        hold = 1'b1;
        push(5'd25, 32'h2525);
        push(5'd26, 32'h2626);
        push(5'd27, 32'h2727);
        hold = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        p0 = wr_pulses;
        @(negedge clk); #1;
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_rst_no_write", 32'(wr_pulses - p0), 32'd0);
        check("mid_rst_count_after", 32'(count), 32'd0);

        check("sb_all_retired", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
